// File: rtl/uart_rx_sampler.sv
// UART receive sampler: synchronises rx, validates the start bit, samples each bit at its
// 16x-baud centre and holds the character under a valid/read handshake. Define RX_FILTER_EN for majority voting.
module uart_rx_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             tick_q, tick_d;
  logic [3:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [SYNC_STAGES-1:0] sync_q;

  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       parity_err_q, parity_err_d;
  logic       framing_err_q, framing_err_d;
  logic       overflow_q, overflow_d;

  logic       rx_s, bit_val, decide, last_tick, complete;
  logic [3:0] nbits;
  logic [7:0] char_w;
  logic       perr_w;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Synchroniser resets to the idle line level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

`ifdef RX_FILTER_EN
  localparam logic [3:0] DECIDE_TICK = 4'd9;
  logic s7_q, s8_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s7_q <= 1'b1;
      s8_q <= 1'b1;
    end else if (baud_clock) begin
      if (tick_q == 4'd7) s7_q <= rx_s;
      if (tick_q == 4'd8) s8_q <= rx_s;
    end
  end

  // 2-of-3 vote over ticks 7, 8 and the live tick-9 sample.
  assign bit_val = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);
`else
  localparam logic [3:0] DECIDE_TICK = 4'd8;
  assign bit_val = rx_s;
`endif

  assign decide    = baud_clock && (tick_q == DECIDE_TICK);
  assign last_tick = baud_clock && (tick_q == 4'hF);
  assign nbits     = bit8 ? 4'd8 : 4'd7;
  assign char_w    = bit8 ? shift_q : {1'b0, shift_q[6:0]};
  assign perr_w    = parity_en & (^char_w ^ par_q ^ odd_n_even);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    complete = 1'b0;

    if (state_q != IDLE && baud_clock) tick_d = tick_q + 4'd1;

    unique case (state_q)
      IDLE: begin
        // The detecting tick is tick 0 of the start bit, so the next tick is tick 1.
        if (baud_clock && !rx_s) begin
          state_d = START;
          tick_d  = 4'd1;
          shift_d = '0;
        end
      end
      START: begin
        if (decide && bit_val) begin
          state_d = IDLE;
          tick_d  = '0;
        end else if (last_tick) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (decide) shift_d[bit_q[2:0]] = bit_val;
        if (last_tick) begin
          bit_d = bit_q + 4'd1;
          if (bit_d == nbits) state_d = parity_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (decide) par_d = bit_val;
        if (last_tick) state_d = STOP;
      end
      STOP: begin
        // Leaving at the decision tick lets a back-to-back start bit be caught on time.
        if (decide) begin
          complete = 1'b1;
          state_d  = IDLE;
          tick_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase
  end

  always_comb begin
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    parity_err_d  = parity_err_q;
    framing_err_d = framing_err_q;
    overflow_d    = overflow_q;

    if (complete) begin
      if (!rx_valid_q || read_rx_byte) begin
        rx_data_d     = char_w;
        rx_valid_d    = 1'b1;
        parity_err_d  = perr_w;
        framing_err_d = ~bit_val;
        if (read_rx_byte) overflow_d = 1'b0;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (read_rx_byte && rx_valid_q) begin
      rx_valid_d    = 1'b0;
      parity_err_d  = 1'b0;
      framing_err_d = 1'b0;
      overflow_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      overflow_q    <= overflow_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = parity_err_q;
  assign framing_err = framing_err_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: frames are driven tick-aligned while a frame-level model
// pushes the expected output snapshots; a monitor compares them as the DUT outputs change.
module tb_uart_rx_sampler;

`ifdef RX_FILTER_EN
  localparam bit FILTER = 1'b1;
  localparam int D      = 9;
`else
  localparam bit FILTER = 1'b0;
  localparam int D      = 8;
`endif

  logic       clk = 1'b0;
  logic       reset_n, baud_clock, rx, bit8, parity_en, odd_n_even, read_rx_byte;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, framing_err, overflow;

  int tests = 0;
  int fails = 0;
  logic [11:0] exp_q[$];
  bit done    = 1'b0;
  bit aligned = 1'b0;

  // Frame-level reference state of the held character.
  bit       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit       m_pe = 1'b0, m_fe = 1'b0, m_ov = 1'b0;

  uart_rx_sampler #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .rx(rx), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .read_rx_byte(read_rx_byte),
    .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
    .framing_err(framing_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    baud_clock = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      baud_clock = 1'b1;
      @(negedge clk);
      baud_clock = 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] m_pack();
    return {m_valid, m_data, m_pe, m_fe, m_ov};
  endfunction

  function automatic logic [11:0] dut_pack();
    return {rx_valid, rx_data, parity_err, framing_err, overflow};
  endfunction

  task automatic model_apply(input bit comp, input bit rd, input logic [7:0] cd,
                             input bit cpe, input bit cfe);
    logic [11:0] old;
    old = m_pack();
    if (comp) begin
      if (!m_valid || rd) begin
        m_data  = cd;
        m_pe    = cpe;
        m_fe    = cfe;
        m_valid = 1'b1;
        if (rd) m_ov = 1'b0;
      end else begin
        m_ov = 1'b1;
      end
    end else if (rd && m_valid) begin
      m_valid = 1'b0;
      m_pe    = 1'b0;
      m_fe    = 1'b0;
      m_ov    = 1'b0;
    end
    if (m_pack() != old) exp_q.push_back(m_pack());
  endtask

  task automatic model_reset();
    logic [11:0] old;
    old = m_pack();
    m_valid = 1'b0; m_data = 8'h00; m_pe = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    if (m_pack() != old) exp_q.push_back(m_pack());
  endtask

  // Monitor: every change of the DUT's output tuple must match the next expected snapshot.
  initial begin
    logic [11:0] prev, cur, e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (done) break;
      cur = dut_pack();
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_change", 32'(cur), 32'(prev));
        end else begin
          e = exp_q.pop_front();
          check("scoreboard", 32'(cur), 32'(e));
        end
        prev = cur;
      end
    end
  end

  task automatic sync_tick();
    do @(posedge clk); while (baud_clock !== 1'b1);
    #1;
    aligned = 1'b1;
  endtask

  // Advance to the next baud tick edge; rd makes read_rx_byte high for exactly that clk edge.
  task automatic tick_step(input bit rd);
    repeat (3) @(posedge clk);
    #1 read_rx_byte = rd;
    @(posedge clk);
    #1 read_rx_byte = 1'b0;
  endtask

  task automatic hw_reset();
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    aligned = 1'b0;
  endtask

  task automatic idle_ticks(input int n, input int read_at);
    for (int e = 1; e <= n; e++) model_apply(1'b0, e == read_at, 8'h00, 1'b0, 1'b0);
    if (!aligned) sync_tick();
    rx = 1'b1;
    for (int e = 1; e <= n; e++) tick_step(e == read_at);
  endtask

  // read_e: -1 none, -2 coincident with completion, else tick index. glitch_e forces one low tick.
  task automatic send_frame(input logic [7:0] data, input bit par_bit, input bit stop_bit,
                            input int read_e_in, input int glitch_e, input int abort_e);
    int n, p, nb, total, comp_e, read_e;
    logic [10:0] bits_v;
    logic [7:0]  cd;
    bit          cpe, cfe;
    n      = bit8 ? 8 : 7;
    p      = parity_en ? 1 : 0;
    nb     = n + p + 2;
    total  = 16 * nb;
    comp_e = 16 * (nb - 1) + 1 + D;
    read_e = (read_e_in == -2) ? comp_e : read_e_in;
    bits_v = '1;
    bits_v[0] = 1'b0;
    for (int i = 0; i < n; i++) bits_v[1 + i] = data[i];
    if (p == 1) bits_v[1 + n] = par_bit;
    bits_v[1 + n + p] = stop_bit;
    cd = data;
    if (n == 7) cd[7] = 1'b0;
    // A glitch placed on a data bit's decision tick corrupts that bit unless majority voting is on.
    if (glitch_e > 0 && !FILTER) cd[glitch_e / 16 - 1] = 1'b0;
    cpe = (p == 1) ? (((($countones(cd) + int'(par_bit)) % 2) != int'(odd_n_even))) : 1'b0;
    cfe = !stop_bit;
    for (int e = 1; e <= total; e++) begin
      model_apply(e == comp_e, e == read_e, cd, cpe, cfe);
      if (e == abort_e) begin
        model_reset();
        break;
      end
    end
    if (!aligned) sync_tick();
    rx = bits_v[0];
    for (int e = 1; e <= total; e++) begin
      tick_step(e == read_e);
      if (e == abort_e) begin
        hw_reset();
        return;
      end
      if (e < total) rx = (e == glitch_e) ? 1'b0 : bits_v[e / 16];
    end
  endtask

  task automatic start_glitch();
    if (!aligned) sync_tick();
    rx = 1'b0;
    repeat (3) tick_step(1'b0);
    rx = 1'b1;
    repeat (20) tick_step(1'b0);
  endtask

  initial begin
    bit prev_stop;
    int r, re;
    reset_n = 1'b1; rx = 1'b1; read_rx_byte = 1'b0;
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);
    check("reset_framing_err", 32'(framing_err), 32'h0);
    check("reset_overflow", 32'(overflow), 32'h0);
    reset_n = 1'b1;

    send_frame(8'hA5, 1'b0, 1'b1, -1, -1, -1);
    check("a5_data", 32'(rx_data), 32'hA5);
    idle_ticks(2, 1);
    check("a5_read_clears_valid", 32'(rx_valid), 32'h0);

    bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b1, -1, -1, -1);
    check("3c_bad_parity", 32'(parity_err), 32'h1);
    idle_ticks(2, 1);
    send_frame(8'h3C, 1'b0, 1'b1, -1, -1, -1);
    check("3c_good_parity", 32'(parity_err), 32'h0);
    idle_ticks(2, 1);

    bit8 = 1'b1; parity_en = 1'b0;
    send_frame(8'h55, 1'b0, 1'b0, -1, -1, -1);
    check("55_framing_err", 32'(framing_err), 32'h1);
    send_frame(8'h0F, 1'b0, 1'b1, 40, -1, -1);
    check("0f_back_to_back", 32'(rx_data), 32'h0F);
    idle_ticks(2, 1);

    send_frame(8'h11, 1'b0, 1'b1, -1, -1, -1);
    send_frame(8'h22, 1'b0, 1'b1, -1, -1, -1);
    check("overflow_set", 32'({overflow, rx_data}), 32'h111);
    idle_ticks(2, 1);
    check("read_clears_flags", 32'({rx_valid, overflow}), 32'h0);
    send_frame(8'h33, 1'b0, 1'b1, -1, -1, -1);
    send_frame(8'h44, 1'b0, 1'b1, -1, -1, -1);
    send_frame(8'h22, 1'b0, 1'b1, -2, -1, -1);
    check("read_with_completion", 32'({rx_valid, overflow, rx_data}), 32'h222);
    idle_ticks(2, 1);

    start_glitch();
    check("false_start_no_valid", 32'(rx_valid), 32'h0);

    send_frame(8'h5A, 1'b0, 1'b1, -1, -1, -1);
    send_frame(8'hFF, 1'b0, 1'b1, -1, -1, 60);
    check("reset_mid_frame", 32'(dut_pack()), 32'h0);
    send_frame(8'h81, 1'b0, 1'b1, -1, -1, -1);
    check("81_after_reset", 32'(rx_data), 32'h81);
    idle_ticks(2, 1);

    send_frame(8'hFF, 1'b0, 1'b1, -1, 24, -1);
    check("ff_data_glitch", 32'(rx_data), FILTER ? 32'hFF : 32'hFE);
    idle_ticks(2, 1);

    prev_stop = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (!prev_stop || $urandom_range(2, 0) == 0)
        idle_ticks(6 + int'($urandom_range(9, 0)), ($urandom_range(1, 0) == 1) ? 1 + int'($urandom_range(3, 0)) : -1);
      if ($urandom_range(3, 0) == 0) begin
        bit8       = 1'($urandom_range(1, 0));
        parity_en  = 1'($urandom_range(1, 0));
        odd_n_even = 1'($urandom_range(1, 0));
      end
      r  = int'($urandom_range(3, 0));
      re = (r == 0) ? -1 : (r == 1) ? -2 : 1 + int'($urandom_range(175, 0));
      prev_stop = ($urandom_range(4, 0) != 0);
      send_frame(8'($urandom), 1'($urandom_range(1, 0)), prev_stop, re, -1, -1);
    end
    if (!prev_stop) idle_ticks(8, -1);
    idle_ticks(2, 1);
    idle_ticks(2, -1);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- UART receive front end; the consumer of the 16x baud_clock pulse from the clock generator.
- Synchronises the serial rx line, detects and validates the start bit, samples data/parity/stop at bit centres, and assembles the character.
- Presents the character with status flags to the register/FIFO layer under a valid/read handshake.

Parameters:
SYNC_STAGES, 2, rx synchroniser depth in flops; legal values 2 or 3.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
baud_clock  input  1  one-clk-wide pulse at 16x baud rate; the only time base
rx  input  1  asynchronous serial line, idle high
bit8  input  1  1 = 8 data bits, 0 = 7 data bits
parity_en  input  1  1 = a parity bit follows the data
odd_n_even  input  1  1 = odd parity, 0 = even parity
read_rx_byte  input  1  one-clk pulse; consumer has taken rx_data
rx_data  output  8  received character, LSB first on the line; bit 7 = 0 in 7-bit mode
rx_valid  output  1  rx_data holds an unread character
parity_err  output  1  parity error for the held character
framing_err  output  1  stop bit was sampled low for the held character
overflow  output  1  sticky; a character completed while rx_valid = 1

Behaviour:
- Reset (async, active low):
  - All outputs 0, rx_data = 0x00.
  - Synchroniser flops reset to 1; FSM in IDLE; counters 0.
  - Assertion mid-frame aborts the frame with no output change beyond the reset values.
- Time base: rx_s is rx after SYNC_STAGES flops. The FSM and tick counter tick_cnt[3:0] advance only on clk edges where baud_clock = 1.
- Decision tick D: 8 by default; 9 with RX_FILTER_EN (see Optional Feature).
- FSM states and transitions:
  - IDLE: on a tick with rx_s = 0, go to START with tick_cnt = 0; that tick counts as tick 0.
  - START: tick_cnt increments each tick. At tick D, a sampled 1 returns the FSM to IDLE (false start, no flags). A sampled 0 continues. At tick 15, go to DATA with tick_cnt = 0 and bit_cnt = 0.
  - DATA: sample at tick D and shift into shift_reg[bit_cnt]. At tick 15, bit_cnt increments. Once bit_cnt reaches 8 (bit8 = 1) or 7 (bit8 = 0), go to PARITY if parity_en, else STOP.
  - PARITY: sample at tick D. Even mode: error if XOR(data bits, parity bit) = 1. Odd mode: error if it = 0. Go to STOP at tick 15.
  - STOP: sample at tick D, then complete the frame and go directly to IDLE. Early return allows back-to-back frames with 1 stop bit.
- Completion (clk edge of the stop decision tick):
  - If rx_valid = 0 or read_rx_byte = 1 in the same cycle: load rx_data, parity_err (0 when parity_en = 0), and framing_err (1 if stop sampled 0); set rx_valid = 1. Completion wins over a simultaneous read.
  - Otherwise: the new character is discarded, held data and flags are unchanged, overflow <= 1.
  - A framing-error character is still delivered.
- read_rx_byte without completion clears rx_valid, parity_err, framing_err and overflow on the next edge. A read while rx_valid = 0 has no effect.
- Latency: rx_valid rises 1 clk after the baud_clock edge of the stop decision tick.
- bit8, parity_en and odd_n_even are sampled continuously. Changing them mid-frame is undefined; they must be changed only in IDLE.

Optional Feature:
- RX_FILTER_EN defined:
  - Each bit (start, data, parity, stop) is decided by a 2-of-3 majority of rx_s at ticks 7, 8 and 9; D = 9.
  - The false-start check uses the majority.
- RX_FILTER_EN undefined:
  - Single sample at tick 8; D = 8; no majority logic is synthesised.

Test Plan:
- baud_clock every 4 clk, bit8 = 1, parity off, send 0xA5 with stop = 1 -> rx_data = 0xA5, rx_valid = 1, parity_err = framing_err = 0. Then pulse read_rx_byte -> rx_valid = 0.
- bit8 = 0, parity_en = 1, even; send 0x3C with parity bit 1 (wrong) -> rx_data = 0x3C, parity_err = 1. Resend 0x3C with parity bit 0 -> parity_err = 0.
- Send 0x55 with stop bit 0 -> rx_data = 0x55, framing_err = 1, rx_valid = 1. A following frame 0x0F with no idle gap is received correctly after a read.
- Send 0x11 then 0x22 with no read -> rx_data stays 0x11, overflow = 1. Read -> all flags 0. A read pulse coincident with the 0x22 completion -> rx_data = 0x22, rx_valid = 1, overflow = 0.
- rx low for 3 ticks then high (glitch) -> FSM returns to IDLE, rx_valid stays 0. Assert reset_n low mid-frame of 0xFF -> all outputs 0, next clean frame 0x81 received correctly.
- Single-tick low glitch at tick 8 of data bit 0 of 0xFF -> with RX_FILTER_EN rx_data = 0xFF; without it rx_data = 0xFE.
